// File: rtl/sap_microsequencer.sv
// SAP CPU micro-sequencer: T-state counter plus microcode decode driving the control-word bus.
// Optional conditional jumps (JC/JZ) and flag-register load enabled by defining SAP_SEQ_COND_JMP_EN.
module sap_microsequencer #(
   parameter int OPCODE_W = 4,
   parameter int CW_W     = 16,
   parameter int STAGE_W  = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                stall,
   input  logic                flag_c,
   input  logic                flag_z,
   output logic [CW_W-1:0]     out,
   output logic [STAGE_W-1:0]  stage,
   output logic                halted,
   output logic                instr_done
);

   localparam int OW = (OPCODE_W > 4) ? OPCODE_W : 4;

   typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5} tstate_e;

   localparam logic [OW-1:0] OP_LDA = OW'(4'h0);
   localparam logic [OW-1:0] OP_ADD = OW'(4'h1);
   localparam logic [OW-1:0] OP_SUB = OW'(4'h2);
   localparam logic [OW-1:0] OP_JMP = OW'(4'h3);
   localparam logic [OW-1:0] OP_JC  = OW'(4'h4);
   localparam logic [OW-1:0] OP_JZ  = OW'(4'h5);
   localparam logic [OW-1:0] OP_STA = OW'(4'h6);
   localparam logic [OW-1:0] OP_OUT = OW'(4'hE);
   localparam logic [OW-1:0] OP_HLT = OW'(4'hF);

`ifdef SAP_SEQ_COND_JMP_EN
   localparam logic [15:0] FLAG_LD = 16'h8000;
`else
   localparam logic [15:0] FLAG_LD = 16'h0000;
`endif

   logic [STAGE_W-1:0] stage_q, stage_d;
   logic [CW_W-1:0]    out_q, out_d;
   logic               halted_q, halted_d;
   logic               done_q, done_d;

   logic [OW-1:0] op_x;
   tstate_e       tstate;
   logic [15:0]   uword;
   logic          ulast;
   logic          uhlt;
   logic          stage_bad;

   // Zero-extend so the 4-bit codes match regardless of OPCODE_W.
   assign op_x      = OW'(opcode);
   assign stage_bad = (stage_q > STAGE_W'(5));
   assign tstate    = tstate_e'(stage_q[2:0]);

`ifndef SAP_SEQ_COND_JMP_EN
   logic unused_flags;
   assign unused_flags = flag_c ^ flag_z;
`endif

   always_comb begin
      uword = '0;
      ulast = 1'b0;
      uhlt  = 1'b0;
      case (tstate)
         T0: uword = 16'h0300;
         T1: uword = 16'h0400;
         T2: uword = 16'h00C0;
         T3: begin
            ulast = 1'b1;
            case (op_x)
               OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                  uword = 16'h0120;
                  ulast = 1'b0;
               end
               OP_JMP: uword = 16'h2020;
               OP_OUT: uword = 16'h1008;
               OP_HLT: begin
                  uword = 16'h0800;
                  uhlt  = 1'b1;
               end
`ifdef SAP_SEQ_COND_JMP_EN
               OP_JC:  uword = flag_c ? 16'h2020 : 16'h0000;
               OP_JZ:  uword = flag_z ? 16'h2020 : 16'h0000;
`endif
               default: uword = '0;
            endcase
         end
         T4: begin
            ulast = 1'b1;
            case (op_x)
               OP_LDA:         uword = 16'h0090;
               OP_ADD, OP_SUB: begin
                  uword = 16'h0084;
                  ulast = 1'b0;
               end
               OP_STA:         uword = 16'h4008;
               default:        uword = '0;
            endcase
         end
         T5: begin
            ulast = 1'b1;
            case (op_x)
               OP_ADD:  uword = 16'h0011 | FLAG_LD;
               OP_SUB:  uword = 16'h0013 | FLAG_LD;
               default: uword = '0;
            endcase
         end
         default: begin
            uword = '0;
            ulast = 1'b1;
         end
      endcase
   end

   always_comb begin
      stage_d  = stage_q;
      out_d    = out_q;
      halted_d = halted_q;
      done_d   = 1'b0;
      if (halted_q) begin
         stage_d = stage_q;
      end else if (stall) begin
         out_d = '0;
      end else if (stage_bad) begin
         stage_d = '0;
         out_d   = '0;
      end else begin
         out_d    = CW_W'(uword);
         done_d   = ulast;
         stage_d  = ulast ? '0 : stage_q + STAGE_W'(1);
         halted_d = uhlt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stage_q  <= '0;
         out_q    <= '0;
         halted_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         stage_q  <= stage_d;
         out_q    <= out_d;
         halted_q <= halted_d;
         done_q   <= done_d;
      end
   end

   assign out        = out_q;
   assign stage      = stage_q;
   assign halted     = halted_q;
   assign instr_done = done_q;

endmodule

// File: tb/tb_sap_microsequencer.sv
// Bench for sap_microsequencer: per-opcode word-list model checked every cycle, plus directed literal sequences.
module tb_sap_microsequencer;

   logic        clk;
   logic        rst;
   logic [3:0]  opcode;
   logic        stall;
   logic        flag_c;
   logic        flag_z;
   logic [15:0] out;
   logic [2:0]  stage;
   logic        halted;
   logic        instr_done;

   int errors = 0;
   int checks = 0;

   sap_microsequencer #(.OPCODE_W(4), .CW_W(16), .STAGE_W(3)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .stall(stall),
      .flag_c(flag_c), .flag_z(flag_z), .out(out), .stage(stage),
      .halted(halted), .instr_done(instr_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: each opcode is a list of control words; position in the list is the T-state.
   logic [15:0] prog [16][6];
   int          plen [16];
   int          m_idx;
   logic [15:0] m_out;
   bit          m_done, m_halt, m_valid;

`ifdef SAP_SEQ_COND_JMP_EN
   localparam bit COND = 1'b1;
`else
   localparam bit COND = 1'b0;
`endif

   initial begin
      for (int op = 0; op < 16; op++) begin
         prog[op][0] = 16'h0300;
         prog[op][1] = 16'h0400;
         prog[op][2] = 16'h00C0;
         prog[op][3] = 16'h0000;
         prog[op][4] = 16'h0000;
         prog[op][5] = 16'h0000;
         plen[op]    = 4;
      end
      prog[0][3] = 16'h0120; prog[0][4] = 16'h0090; plen[0] = 5;
      prog[1][3] = 16'h0120; prog[1][4] = 16'h0084; prog[1][5] = COND ? 16'h8011 : 16'h0011; plen[1] = 6;
      prog[2][3] = 16'h0120; prog[2][4] = 16'h0084; prog[2][5] = COND ? 16'h8013 : 16'h0013; plen[2] = 6;
      prog[3][3] = 16'h2020;
      prog[6][3] = 16'h0120; prog[6][4] = 16'h4008; plen[6] = 5;
      prog[14][3] = 16'h1008;
      prog[15][3] = 16'h0800;
      m_idx = 0; m_out = '0; m_done = 0; m_halt = 0; m_valid = 0;
   end

   always @(posedge clk) begin
      if (rst) begin
         m_idx = 0; m_out = '0; m_done = 0; m_halt = 0; m_valid = 1;
      end else if (m_halt) begin
         m_done = 0;
      end else if (stall) begin
         m_out = '0; m_done = 0;
      end else begin
         m_out = prog[opcode][m_idx];
         if (COND && m_idx == 3 && opcode == 4'h4) m_out = flag_c ? 16'h2020 : 16'h0000;
         if (COND && m_idx == 3 && opcode == 4'h5) m_out = flag_z ? 16'h2020 : 16'h0000;
         m_done = (m_idx == plen[opcode] - 1);
         if (opcode == 4'hF && m_idx == 3) m_halt = 1;
         m_idx = m_done ? 0 : m_idx + 1;
      end
      #1;
      if (m_valid) begin
         checks++;
         if (out !== m_out || stage !== 3'(m_idx) || instr_done !== m_done || halted !== m_halt) begin
            errors++;
            $display("FAIL model t=%0t: out=%h stage=%0d done=%b halted=%b, want out=%h stage=%0d done=%b halted=%b",
                     $time, out, stage, instr_done, halted, m_out, m_idx, m_done, m_halt);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string nm, input logic [15:0] e_out, input int e_stage, input bit e_done);
      checks++;
      if (out !== e_out || stage !== 3'(e_stage) || instr_done !== e_done) begin
         errors++;
         $display("FAIL %s: out=%h stage=%0d done=%b, want out=%h stage=%0d done=%b",
                  nm, out, stage, instr_done, e_out, e_stage, e_done);
      end
   endtask

   task automatic chk_h(input string nm, input bit e_h);
      checks++;
      if (halted !== e_h) begin
         errors++;
         $display("FAIL %s: halted=%b, want %b", nm, halted, e_h);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      chk("reset", 16'h0000, 0, 1'b0);
      rst = 1'b0;
   endtask

   task automatic run_instr(input string nm, input logic [3:0] op, input int n,
                            input logic [15:0] w3, input logic [15:0] w4, input logic [15:0] w5);
      logic [15:0] e;
      opcode = op;
      for (int k = 0; k < n; k++) begin
         case (k)
            0: e = 16'h0300;
            1: e = 16'h0400;
            2: e = 16'h00C0;
            3: e = w3;
            4: e = w4;
            default: e = w5;
         endcase
         tick();
         chk(nm, e, (k == n - 1) ? 0 : k + 1, k == n - 1);
      end
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; opcode = 4'h0; flag_c = 1'b0; flag_z = 1'b0;
      tick();
      chk("rst_cyc1", 16'h0000, 0, 1'b0);
      tick();
      chk("rst_cyc2", 16'h0000, 0, 1'b0);
      chk_h("rst_halt", 1'b0);
      rst = 1'b0;
      run_instr("lda", 4'h0, 5, 16'h0120, 16'h0090, 16'h0000);
      tick();
      chk("lda_refetch", 16'h0300, 1, 1'b0);

      do_reset();
      run_instr("add", 4'h1, 6, 16'h0120, 16'h0084, COND ? 16'h8011 : 16'h0011);
      run_instr("sub", 4'h2, 6, 16'h0120, 16'h0084, COND ? 16'h8013 : 16'h0013);
      run_instr("jmp", 4'h3, 4, 16'h2020, 16'h0000, 16'h0000);
      run_instr("out", 4'hE, 4, 16'h1008, 16'h0000, 16'h0000);
      run_instr("sta", 4'h6, 5, 16'h0120, 16'h4008, 16'h0000);
      run_instr("nop", 4'h9, 4, 16'h0000, 16'h0000, 16'h0000);

      do_reset();
      opcode = 4'h0;
      tick(); chk("stall_t0", 16'h0300, 1, 1'b0);
      tick(); chk("stall_t1", 16'h0400, 2, 1'b0);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(); chk("stall_hold", 16'h0000, 2, 1'b0);
      end
      stall = 1'b0;
      tick(); chk("stall_resume", 16'h00C0, 3, 1'b0);
      tick(); chk("stall_t3", 16'h0120, 4, 1'b0);
      tick(); chk("stall_t4", 16'h0090, 0, 1'b1);

      do_reset();
      run_instr("hlt", 4'hF, 4, 16'h0800, 16'h0000, 16'h0000);
      chk_h("hlt_set", 1'b1);
      for (int i = 0; i < 20; i++) begin
         stall = (i % 2 == 0);
         opcode = 4'(i);
         tick();
         chk("hlt_frozen", 16'h0800, 0, 1'b0);
         chk_h("hlt_sticky", 1'b1);
      end
      stall = 1'b0;
      rst = 1'b1;
      tick(); chk("hlt_rst", 16'h0000, 0, 1'b0);
      chk_h("hlt_clear", 1'b0);
      rst = 1'b0;
      opcode = 4'h0;
      tick(); chk("hlt_refetch", 16'h0300, 1, 1'b0);

      do_reset();
      opcode = 4'h1;
      for (int i = 0; i < 4; i++) tick();
      chk("abort_pre", 16'h0120, 4, 1'b0);
      rst = 1'b1;
      tick(); chk("abort_rst", 16'h0000, 0, 1'b0);
      rst = 1'b0;
      tick(); chk("abort_fetch", 16'h0300, 1, 1'b0);
      tick(); chk("abort_t1", 16'h0400, 2, 1'b0);

      do_reset();
      flag_c = 1'b1; flag_z = 1'b0;
      run_instr("jc_c1", 4'h4, 4, COND ? 16'h2020 : 16'h0000, 16'h0000, 16'h0000);
      flag_c = 1'b0; flag_z = 1'b1;
      run_instr("jc_c0", 4'h4, 4, 16'h0000, 16'h0000, 16'h0000);
      run_instr("jz_z1", 4'h5, 4, COND ? 16'h2020 : 16'h0000, 16'h0000, 16'h0000);
      flag_c = 1'b1; flag_z = 1'b0;
      run_instr("jz_z0", 4'h5, 4, 16'h0000, 16'h0000, 16'h0000);

      for (int i = 0; i < 3000; i++) begin
         rst    = ($urandom_range(0, 99) == 0) || (m_halt && $urandom_range(0, 7) == 0);
         stall  = ($urandom_range(0, 6) == 0);
         flag_c = 1'($urandom);
         flag_z = 1'($urandom);
         if (m_idx == 0) opcode = 4'($urandom_range(0, 15));
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
